// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

   localparam int NUM_PORTS = 2;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported 256x8 data memory.
// Port 0 is the processor load/store path, port 1 the bulk loader/DMA path.
// Grant is combinational. Read data comes back one cycle after grant, tagged to
// the port that issued the read.
//
// state | meaning
// IDLE  | no owner; round-robin between requesters, tie goes to port != last_gnt
// OWN0  | port 0 holds a lock; port 1 is held off
// OWN1  | port 1 holds a lock; port 0 is held off
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] we_i,
   input  logic [NUM_PORTS-1:0] lock_i,
   input  logic [ADDR_W-1:0]    addr0_i,
   input  logic [ADDR_W-1:0]    addr1_i,
   input  logic [DATA_W-1:0]    wdata0_i,
   input  logic [DATA_W-1:0]    wdata1_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [NUM_PORTS-1:0] rvalid_o,
   output logic [DATA_W-1:0]    rdata_o,
   output logic                 mem_wen_o,
   output logic                 mem_ren_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [DATA_W-1:0]    mem_wdata_o,
   input  logic [DATA_W-1:0]    mem_rdata_i
);

   localparam logic [7:0] LOCK_LIMIT = LOCK_MAX[7:0];

   arb_state_t           state;
   logic                 last_gnt;
   logic [7:0]           lock_cnt;
   logic                 rd_pend;
   logic                 rd_tag;

   logic [NUM_PORTS-1:0] gnt;
   logic                 granted;
   logic                 sel;
   logic                 is_read;
   logic [7:0]           cnt_inc;

   // Grant selection: round-robin in IDLE, owner-only while locked, nothing in reset.
   always_comb begin
      gnt = '0;
      case (state)
         IDLE: begin
            if (req_i[0] && (!req_i[1] || last_gnt))
               gnt = 2'b01;
            else if (req_i[1])
               gnt = 2'b10;
         end
         OWN0:    gnt[0] = req_i[0];
         OWN1:    gnt[1] = req_i[1];
         default: gnt = '0;
      endcase
      if (reset)
         gnt = '0;
   end

   assign granted = |gnt;
   assign sel     = gnt[1];
   assign is_read = granted & ~we_i[sel];

   // Saturating so a misconfigured LOCK_MAX can never wrap the count.
   assign cnt_inc = (lock_cnt == 8'hFF) ? 8'hFF : lock_cnt + 8'd1;

   // Memory pin drive, muxed from the granted port and zero when idle.
   always_comb begin
      mem_wen_o   = granted & we_i[sel];
      mem_ren_o   = is_read;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (granted) begin
         mem_addr_o  = sel ? addr1_i  : addr0_i;
         mem_wdata_o = sel ? wdata1_i : wdata0_i;
      end
   end

   assign gnt_o = gnt;

   // Ownership FSM, round-robin history and read tagging.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         lock_cnt <= '0;
         rd_pend  <= 1'b0;
         rd_tag   <= 1'b0;
      end else begin
         rd_pend <= is_read;
         if (is_read)
            rd_tag <= sel;
         if (granted)
            last_gnt <= sel;

         case (state)
            IDLE: begin
               // LOCK_MAX of 1 means the entry grant already uses the whole budget.
               if (granted && lock_i[sel] && (LOCK_LIMIT > 8'd1)) begin
                  state    <= sel ? OWN1 : OWN0;
                  lock_cnt <= 8'd1;
               end
            end
            OWN0, OWN1: begin
               // cnt_inc counts the transfer happening now; release once it hits the limit.
               if (!granted || !lock_i[sel] || (cnt_inc >= LOCK_LIMIT)) begin
                  state    <= IDLE;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= cnt_inc;
               end
            end
            default: begin
               state    <= IDLE;
               lock_cnt <= '0;
            end
         endcase
      end
   end

   // Memory already registers read data, so only the strobe is ours.
   always_comb begin
      rvalid_o = '0;
      if (rd_pend && !reset)
         rvalid_o[rd_tag] = 1'b1;
   end

   assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, random traffic against a
// transaction-level model, and a reset-during-read sequence.
module tb_dmem_arbiter;

   localparam int LMAX = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req_i = '0, we_i = '0, lock_i = '0;
   logic [7:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
   logic [1:0] gnt_o, rvalid_o;
   logic [7:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [7:0] mem_rdata_i = '0;
   logic       mem_wen_o, mem_ren_o;

   dmem_arbiter #(.LOCK_MAX(LMAX)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
      .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   // Data memory: 256x8, registered read.
   logic [7:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
   always @(posedge clk) begin
      if (mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
      if (mem_ren_o) mem_rdata_i <= mem[mem_addr_o];
   end

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   // Transaction-level model: who owns the memory, how many grants the current
   // burst has used, and what response is due next cycle.
   logic [7:0] shadow [256];
   int         owner;
   int         last;
   int         burst;
   logic [1:0] exp_rv;
   logic [7:0] exp_rd;
   int         cur_g;

   function automatic void model_reset();
      owner  = -1;
      last   = 1;
      burst  = 0;
      exp_rv = 2'b00;
   endfunction

   function automatic int pick(input logic [1:0] req);
      if (owner >= 0) return req[owner] ? owner : -1;
      case (req)
         2'b01:   return 0;
         2'b10:   return 1;
         2'b11:   return (last == 0) ? 1 : 0;
         default: return -1;
      endcase
   endfunction

   task automatic step(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
      int g;
      logic [7:0] ea;
      @(negedge clk);
      req_i = req; we_i = we; lock_i = lock;
      addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
      #1;
      chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
      if (exp_rv != 2'b00) chk("rdata", 32'(rdata_o), 32'(exp_rd));
      g = pick(req);
      cur_g = g;
      chk("gnt", 32'(gnt_o), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("onehot0", 32'($onehot0(gnt_o)), 32'd1);
      chk("wen_ren_excl", 32'(mem_wen_o & mem_ren_o), 32'd0);
      chk("wen", 32'(mem_wen_o), 32'((g >= 0) && we[g]));
      chk("ren", 32'(mem_ren_o), 32'((g >= 0) && !we[g]));
      chk("addr", 32'(mem_addr_o), (g < 0) ? 32'd0 : 32'((g == 1) ? a1 : a0));
      chk("wdata", 32'(mem_wdata_o), (g < 0) ? 32'd0 : 32'((g == 1) ? d1 : d0));
      exp_rv = 2'b00;
      if (g >= 0) begin
         last = g;
         ea = (g == 1) ? a1 : a0;
         if (we[g]) shadow[ea] = (g == 1) ? d1 : d0;
         else begin
            exp_rv = 2'(1 << g);
            exp_rd = shadow[ea];
         end
      end
      if (owner < 0) begin
         if (g >= 0 && lock[g] && LMAX > 1) begin
            owner = g;
            burst = 1;
         end
      end else if (g < 0) begin
         owner = -1;
      end else begin
         burst++;
         if (!lock[g] || burst >= LMAX) owner = -1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_i = 2'b11; we_i = 2'b00;
      #1;
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_wen", 32'(mem_wen_o), 32'd0);
      chk("rst_ren", 32'(mem_ren_o), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req_i = 2'b00;
      model_reset();
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] req, we, lock;
      logic [7:0] a0, a1, d0, d1;
      logic [1:0] gnt, rv;
      logic [7:0] rd;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] we,
                               input logic [1:0] lock, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] gnt, input logic [1:0] rv, input logic [7:0] rd);
      vec_t v;
      v.rst = rst; v.req = req; v.we = we; v.lock = lock;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.gnt = gnt; v.rv = rv; v.rd = rd;
      return v;
   endfunction

   vec_t tbl[$];

   logic [1:0] rq, rwe, rl;
   logic [7:0] ra [2];
   logic [7:0] rdt [2];

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA5;
      model_reset();
      cur_g = -1;
      exp_rd = '0;

      // Write then read back from port 0.
      tbl.push_back(mk(1, 2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 8'h5A, 8'h00, 2'b01, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5A));
      // Continuous read tie: alternation and tagged responses (0x20->85, 0x21->84).
      tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00, 2'b10, 2'b01, 8'h85));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00, 2'b01, 2'b10, 8'h84));
      tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00, 2'b10, 2'b01, 8'h85));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h84));
      // Port 1 lock burst limited to LOCK_MAX=4 grants.
      tbl.push_back(mk(1, 2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 8'h01, 8'h00, 2'b01, 2'b00, 8'h00));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 2'b11, 2'b10, 2'b10, 8'h40, 8'h50, 8'h00, 8'hAA, 2'b10, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b11, 2'b10, 2'b10, 8'h40, 8'h50, 8'h00, 8'hAA, 2'b01, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h01));
      // Port 1 drops lock on its second transfer.
      tbl.push_back(mk(1, 2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 8'h02, 8'h00, 2'b01, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b11, 2'b10, 2'b10, 8'h40, 8'h51, 8'h00, 8'hBB, 2'b10, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 8'h40, 8'h51, 8'h00, 8'hBB, 2'b10, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 8'h40, 8'h51, 8'h00, 8'hBB, 2'b01, 2'b00, 8'h00));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h02));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid_o), 32'(tbl[i].rv));
         if (tbl[i].rv != 2'b00)
            chk($sformatf("tbl%0d_rdata", i), 32'(rdata_o), 32'(tbl[i].rd));
      end

      // Random traffic; ports hold their request until granted.
      do_reset();
      rq = '0; rwe = '0; rl = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!rq[p] && ($urandom_range(0, 9) < 6)) begin
               rq[p]  = 1'b1;
               rwe[p] = 1'($urandom_range(0, 1));
               ra[p]  = 8'($urandom_range(0, 15));
               rdt[p] = 8'($urandom);
            end
            rl[p] = ($urandom_range(0, 3) != 0);
         end
         step(rq, rwe, rl, ra[0], ra[1], rdt[0], rdt[1]);
         if (cur_g >= 0) rq[cur_g] = 1'b0;
      end
      step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

      // Reset lands on the response cycle of a read.
      do_reset();
      step(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      req_i = 2'b00;
      #1;
      chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
      model_reset();
      @(negedge clk);
      chk("midrst_rvalid_hold", 32'(rvalid_o), 32'd0);
      reset = 1'b0;
      step(2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00);
      chk("midrst_tie_gnt", 32'(gnt_o), 32'd1);
      step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port request arbiter that shares the single-ported 8-bit data memory (256 × 8, registered read, write-priority) between the processor load/store path (port 0) and the bulk loader/DMA path (port 1). The arbiter grants at most one transfer per cycle using round-robin priority. It supports a bounded lock for back-to-back bursts and returns read data to the port that issued the read, one cycle after grant. It sits between both requesters and the memory's `wen`/`ren`/`address`/`writeData`/`readData` pins.

## Interface
- `LOCK_MAX`, default 16: maximum consecutive locked grants to one port before ownership is forcibly released. Valid range is 1..255.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_i[1:0]` input 2: per-port transfer request. Bit 0 is the processor port, bit 1 is the loader port.
- `we_i[1:0]` input 2: per-port write enable. 1 means write; 0 means read.
- `lock_i[1:0]` input 2: per-port request to keep ownership after this transfer.
- `addr0_i`, `addr1_i` input 8: per-port byte address.
- `wdata0_i`, `wdata1_i` input 8: per-port write data.
- `gnt_o[1:0]` output 2: combinational grant, one-hot or zero. A transfer occurs on a cycle where `req_i[p] & gnt_o[p]` is high.
- `rvalid_o[1:0]` output 2: registered read-response strobe to port p.
- `rdata_o` output 8: read data, shared by both ports. Qualified by `rvalid_o`.
- `mem_wen_o`, `mem_ren_o` output 1: drive the memory `wen`/`ren`. These are never both high.
- `mem_addr_o`, `mem_wdata_o` output 8: muxed from the granted port. Outputs 0 when no grant.
- `mem_rdata_i` input 8: memory `readData`.

## Operation
- FSM states are IDLE, OWN0 and OWN1.
- IDLE behaviour:
  - With a single requester, that port is granted.
  - With both requesting, the port that is not `last_gnt` is granted.
  - `last_gnt` resets to 1, so port 0 wins the first tie.
- OWNp behaviour: only port p can be granted. Port `1-p` is held off even while it requests.
- Entering OWNp: a grant to p with `lock_i[p]=1` moves the FSM to OWNp and loads `lock_cnt` with 1.
- While in OWNp, each granted locked transfer increments `lock_cnt`.
- Leaving OWNp: the FSM returns to IDLE on the first cycle where any of the following holds:
  - `req_i[p]=0`;
  - `lock_i[p]=0`, in which case that transfer is still performed;
  - `lock_cnt==LOCK_MAX`, in which case this transfer is performed and the lock is ignored.
- `last_gnt` updates to the granted port on every grant, including locked grants.
- Memory drive:
  - `mem_wen_o = grant & we_i[g]`.
  - `mem_ren_o = grant & ~we_i[g]`.
  - Address and write data come from port g.
- Read tagging: on a granted read, `rd_tag <= g` and `rd_pend <= 1`. In all other cycles `rd_pend <= 0`.
- Read response: `rvalid_o[rd_tag] = rd_pend` and `rdata_o = mem_rdata_i`. The arbiter does not add its own data register, because the memory already registers read data.
- Writes produce no response and complete at the grant edge.
- A port must hold `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high. The arbiter does not capture requests.

## Timing
- Grant is combinational in the same cycle as the request. There is no request-to-grant latency when the port wins arbitration.
- Read latency: granted in cycle N, the memory samples at the end of N, and `rvalid_o`/`rdata_o` are valid throughout cycle N+1.
- Full throughput is one transfer per cycle. A read followed immediately by any transfer is legal; the response for N is in N+1, concurrent with the grant for N+1.
- Reset values and behaviour:
  - FSM = IDLE, `last_gnt` = 1, `lock_cnt` = 0, `rd_pend` = 0, `rd_tag` = 0.
  - `gnt_o`, `rvalid_o`, `mem_wen_o` and `mem_ren_o` are forced to 0 while `reset` is high.
  - `rdata_o` follows `mem_rdata_i` but is meaningless without `rvalid_o`.
- Reset mid-operation: asserting reset in cycle N+1 of a pending read suppresses `rvalid_o` immediately. Any lock ownership is dropped.
- `lock_cnt` is 8 bits and saturates. It never wraps because release is forced at `LOCK_MAX`.

## Structure
- Shared package `dmem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t`;
  - `localparam NUM_PORTS = 2`, `ADDR_W = 8`, `DATA_W = 8`.
- Single module with no sub-module. Round-robin selection for two ports is a few gates and does not warrant its own block.
- The top level instantiates `dmem_arbiter` in front of the data memory. The memory itself is unchanged.

## Test plan
- Port 0 writes 0x5A to addr 0x10 with port 1 idle → `gnt_o=01` and `mem_wen_o=1` that cycle. A later port-0 read of 0x10 → `rvalid_o=01` and `rdata_o=0x5A` exactly one cycle after grant.
- Both ports request reads (0x20 and 0x21) continuously for 4 cycles after reset → grants 01,10,01,10. `rvalid_o` is 01,10,01,10 one cycle later, each carrying the matching data.
- Port 1 locks with `LOCK_MAX=4` while port 0 requests continuously → port 1 is granted 4 consecutive cycles, then port 0 is granted on cycle 5.
- Port 1 locks then drops `lock_i` on its 2nd transfer → the 2nd transfer completes and port 0 is granted on the next cycle.
- Read granted, then `reset` is asserted on the following cycle → `rvalid_o` stays 00. After release, the first tie is granted to port 0.
- Random traffic with a scoreboard → `mem_wen_o & mem_ren_o` never high, `gnt_o` is one-hot or zero, and every granted read has exactly one `rvalid_o` to the correct port.
